// File: rtl/tsu_bus_master_pkg.sv
// tsu_bus_master shared types: FSM states, FIFO depth default and command word.
// Command word layout is {wr, addr[31:0], wdata[31:0]} = 65 bits.
package tsu_bus_master_pkg;

  localparam int TSU_BM_FIFO_DEPTH = 4;
  localparam int TSU_BM_CMD_W = 65;

  typedef enum logic [1:0] {
    TSU_BM_IDLE    = 2'd0,
    TSU_BM_ISSUE   = 2'd1,
    TSU_BM_RD_WAIT = 2'd2,
    TSU_BM_RESP    = 2'd3
  } tsu_bm_state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tsu_bm_cmd_t;

endpackage

// File: rtl/tsu_bus_master_if.sv
// tsu_bus_master_if: request/response channels and register bus signals.
// master = the bus master block, slave = host agent plus bus slave side.
interface tsu_bus_master_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_wr_o;
  logic [31:0] rsp_addr_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] bus2ip_addr_o;
  logic [31:0] bus2ip_data_o;
  logic        bus2ip_rd_ce_o;
  logic        bus2ip_wr_ce_o;
  logic [31:0] ip2bus_data_i;
  logic        busy_o;

  modport master (
    input  req_valid_i, req_wr_i, req_addr_i,
    input  req_wdata_i, rsp_ready_i, ip2bus_data_i,
    output req_ready_o, rsp_valid_o, rsp_wr_o,
    output rsp_addr_o, rsp_rdata_o, bus2ip_addr_o,
    output bus2ip_data_o, bus2ip_rd_ce_o,
    output bus2ip_wr_ce_o, busy_o
  );

  modport slave (
    output req_valid_i, req_wr_i, req_addr_i,
    output req_wdata_i, rsp_ready_i, ip2bus_data_i,
    input  req_ready_o, rsp_valid_o, rsp_wr_o,
    input  rsp_addr_o, rsp_rdata_o, bus2ip_addr_o,
    input  bus2ip_data_o, bus2ip_rd_ce_o,
    input  bus2ip_wr_ce_o, busy_o
  );

endinterface

// File: rtl/tsu_bus_cmd_fifo.sv
// tsu_bus_cmd_fifo: synchronous command FIFO with wrap-bit pointers.
// Ports: clk, rst_n (sync, active low), push/din, pop/dout, full, empty.
module tsu_bus_cmd_fifo
  import tsu_bus_master_pkg::*;
#(
  parameter int DEPTH = TSU_BM_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  tsu_bm_cmd_t din,
  input  logic        pop,
  output tsu_bm_cmd_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  tsu_bm_cmd_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/tsu_bus_master.sv
// tsu_bus_master: queues single-word commands and runs one register bus access at a time.
// Ports: bus2ip_clk, bus2ip_rst_n (sync, active low), bm (tsu_bus_master_if.master:
// req/rsp channels, bus2ip_* strobes/addr/data, ip2bus_data_i, busy_o).
// TSU_BUS_MASTER_CNT_EN adds rd_cnt_o/wr_cnt_o access counters.
module tsu_bus_master
  import tsu_bus_master_pkg::*;
#(
  parameter int FIFO_DEPTH = TSU_BM_FIFO_DEPTH,
  parameter int RD_LAT     = 1
) (
  input  logic               bus2ip_clk,
  input  logic               bus2ip_rst_n,
  tsu_bus_master_if.master   bm
`ifdef TSU_BUS_MASTER_CNT_EN
  ,
  output logic [15:0]        rd_cnt_o,
  output logic [15:0]        wr_cnt_o
`endif
);

  tsu_bm_state_e state_q;
  tsu_bm_state_e state_d;
  tsu_bm_cmd_t   push_cmd;
  tsu_bm_cmd_t   pop_cmd;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [2:0]    wait_q;
  logic [2:0]    wait_d;
  logic          cmd_wr_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [31:0]   rdata_q;
  logic          issue;
  logic          capture;

  assign push          = bm.req_valid_i && !full;
  assign push_cmd.wr    = bm.req_wr_i;
  assign push_cmd.addr  = bm.req_addr_i;
  assign push_cmd.wdata = bm.req_wdata_i;

  tsu_bus_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (bus2ip_clk),
    .rst_n (bus2ip_rst_n),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (pop_cmd),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    unique case (state_q)
      TSU_BM_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = TSU_BM_ISSUE;
        end
      end
      TSU_BM_ISSUE: begin
        if (cmd_wr_q) begin
          state_d = TSU_BM_RESP;
        end else begin
          wait_d  = 3'(RD_LAT - 1);
          state_d = TSU_BM_RD_WAIT;
        end
      end
      TSU_BM_RD_WAIT: begin
        if (wait_q == 3'd0) state_d = TSU_BM_RESP;
        else                wait_d  = wait_q - 3'd1;
      end
      TSU_BM_RESP: begin
        if (bm.rsp_ready_i) state_d = TSU_BM_IDLE;
      end
      default: state_d = TSU_BM_IDLE;
    endcase
  end

  assign issue   = (state_q == TSU_BM_ISSUE);
  assign capture = (state_q == TSU_BM_RD_WAIT) &&
                   (wait_q == 3'd0);

  always_ff @(posedge bus2ip_clk) begin
    if (!bus2ip_rst_n) begin
      state_q  <= TSU_BM_IDLE;
      wait_q   <= '0;
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (pop) begin
        cmd_wr_q <= pop_cmd.wr;
        addr_q   <= pop_cmd.addr;
        data_q   <= pop_cmd.wdata;
      end
      if (issue && cmd_wr_q) rdata_q <= '0;
      if (capture)           rdata_q <= bm.ip2bus_data_i;
    end
  end

  assign bm.req_ready_o    = !full;
  assign bm.rsp_valid_o    = (state_q == TSU_BM_RESP);
  assign bm.rsp_wr_o       = cmd_wr_q;
  assign bm.rsp_addr_o     = addr_q;
  assign bm.rsp_rdata_o    = rdata_q;
  assign bm.bus2ip_addr_o  = addr_q;
  assign bm.bus2ip_data_o  = data_q;
  assign bm.bus2ip_rd_ce_o = issue && !cmd_wr_q;
  assign bm.bus2ip_wr_ce_o = issue && cmd_wr_q;
  assign bm.busy_o         = (state_q != TSU_BM_IDLE) || !empty;

`ifdef TSU_BUS_MASTER_CNT_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge bus2ip_clk) begin
    if (!bus2ip_rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (issue) begin
      if (cmd_wr_q) wr_cnt_q <= wr_cnt_q + 16'd1;
      else          rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
